// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data ports onto one memory port,
// one outstanding transaction, data priority with a fetch anti-starvation counter.
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [1:0]  i_d_sz,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, ERR} state_t;
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  starve_q, starve_d;
  logic        sel_if, gnt_if, gnt_d, misalign, rsp;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        unused_if_addr;
  assign unused_if_addr = ^i_if_addr[1:0];
  // Grants are gated by reset so every output is 0 while i_rst_n is low.
  always_comb begin
    sel_if   = i_if_req & (~i_d_req | (starve_q == 2'd3));
    gnt_if   = (state_q == IDLE) & i_rst_n & sel_if;
    gnt_d    = (state_q == IDLE) & i_rst_n & i_d_req & ~sel_if;
    misalign = (i_d_sz == 2'b11) | ((i_d_sz == 2'b01) & i_d_addr[0]) |
               ((i_d_sz == 2'b10) & (i_d_addr[1:0] != 2'b00));
    rsp      = (state_q == WAIT_RSP) & i_mem_rvalid;
    d_be     = (i_d_sz == 2'b00) ? 4'b0001 << i_d_addr[1:0] :
               (i_d_sz == 2'b01) ? (i_d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    d_wdata  = (i_d_sz == 2'b00) ? {4{i_d_wdata[7:0]}} :
               (i_d_sz == 2'b01) ? {2{i_d_wdata[15:0]}} : i_d_wdata;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = (gnt_d & misalign) ? ERR : (gnt_if | gnt_d) ? WAIT_GNT : IDLE;
      WAIT_GNT: state_d = i_mem_gnt ? WAIT_RSP : WAIT_GNT;
      WAIT_RSP: state_d = i_mem_rvalid ? IDLE : WAIT_RSP;
      default:  state_d = IDLE;
    endcase
  end
  // Request fields are captured at grant; misaligned grants count toward starvation too.
  always_comb begin
    owner_d  = gnt_d ? 1'b1 : gnt_if ? 1'b0 : owner_q;
    we_d     = gnt_d ? i_d_we : gnt_if ? 1'b0 : we_q;
    addr_d   = gnt_d ? {i_d_addr[31:2], 2'b00} : gnt_if ? {i_if_addr[31:2], 2'b00} : addr_q;
    be_d     = gnt_d ? d_be : gnt_if ? 4'b1111 : be_q;
    wdata_d  = gnt_d ? d_wdata : gnt_if ? 32'd0 : wdata_q;
    starve_d = (state_q != IDLE) ? starve_q :
               (gnt_d & i_if_req) ? ((starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1) :
               (gnt_if | ~i_if_req) ? 2'd0 : starve_q;
  end
  always_comb begin
    o_if_gnt    = gnt_if;
    o_d_gnt     = gnt_d;
    o_mem_req   = (state_q == WAIT_GNT);
    o_mem_we    = we_q;
    o_mem_addr  = addr_q;
    o_mem_be    = be_q;
    o_mem_wdata = wdata_q;
    o_if_rvalid = rsp & ~owner_q;
    o_if_rdata  = (rsp & ~owner_q) ? i_mem_rdata : 32'd0;
    o_d_rvalid  = (rsp & owner_q) | (state_q == ERR);
    o_d_rdata   = (rsp & owner_q) ? i_mem_rdata : 32'd0;
    o_d_err     = (state_q == ERR);
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have i_clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have i_if_req input 1, i_if_addr input 32: fetch read request and byte address; addr[1:0] ignored.
REQ-004 SHALL have o_if_gnt output 1, o_if_rvalid output 1, o_if_rdata output 32: fetch accept pulse, response pulse, instruction word.
REQ-005 SHALL have i_d_req input 1, i_d_we input 1, i_d_sz input 2 (00 BYTE, 01 HWORD, 10 WORD), i_d_addr input 32, i_d_wdata input 32: data load/store request.
REQ-006 SHALL have o_d_gnt output 1, o_d_rvalid output 1, o_d_rdata output 32, o_d_err output 1: data accept, response, raw aligned word, misalign error.
REQ-007 SHALL have o_mem_req output 1, o_mem_we output 1, o_mem_addr output 32 (bits[1:0]=0), o_mem_be output 4, o_mem_wdata output 32: shared memory port request.
REQ-008 SHALL have i_mem_gnt input 1, i_mem_rvalid input 1, i_mem_rdata input 32: memory accept and response (reads and stores both respond).

Function
REQ-009 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RSP, ERR; exactly one transaction outstanding.
REQ-010 IDLE: if any request, select owner, pulse owner's gnt combinationally that cycle, latch request fields, go to WAIT_GNT; requesters hold req until gnt.
REQ-011 Priority: data over fetch, except fetch wins when starve counter = 3 and i_if_req=1.
REQ-012 Starve counter (2-bit): +1 on each data grant while i_if_req=1, saturates at 3, clears on fetch grant or when i_if_req=0 in IDLE.
REQ-013 WAIT_GNT: o_mem_req=1 with latched fields, stable until i_mem_gnt=1, then WAIT_RSP.
REQ-014 WAIT_RSP: o_mem_req=0; on i_mem_rvalid=1 pulse owner's rvalid same cycle, rdata = i_mem_rdata pass-through, return to IDLE.
REQ-015 Zero-wait memory: grant cycle N, o_mem_req cycle N+1, earliest rvalid cycle N+2, next grant cycle N+3.
REQ-016 Byte enables: BYTE -> 4'b0001<<addr[1:0]; HWORD -> addr[1]?4'b1100:4'b0011; WORD -> 4'b1111; fetch -> 4'b1111, we=0.
REQ-017 Write data lane replication: BYTE -> {4{wdata[7:0]}}, HWORD -> {2{wdata[15:0]}}, WORD -> wdata.
REQ-018 Misaligned data (HWORD addr[0]=1, WORD addr[1:0]!=0, or sz=11): gnt given, no memory access, go ERR; next cycle o_d_rvalid=1, o_d_err=1, o_d_rdata=0, then IDLE.
REQ-019 o_d_err SHALL be 0 on every non-ERR response; o_if_rvalid and o_d_rvalid never both 1.
REQ-020 i_mem_rvalid in IDLE/WAIT_GNT SHALL be ignored (no response pulse).
REQ-021 Simultaneous i_if_req and i_d_req in IDLE: exactly one gnt per cycle; loser stays pending.
REQ-022 Misaligned data requests SHALL count toward starve counter identically to aligned ones.

Reset
REQ-023 On i_rst_n=0 immediately: state IDLE, starve counter 0, latched fields 0, all outputs 0.
REQ-024 Reset mid-transaction abandons it; memory responses arriving after release are dropped per REQ-020.
REQ-025 First grant possible in the first clock edge with i_rst_n=1.

Verification
REQ-026 Fetch only, addr 0x0000_1006, mem gnt same cycle, rvalid next with 0x0000_0013 -> o_mem_addr 0x0000_1004, be 1111, o_if_rvalid with 0x0000_0013 at N+2.
REQ-027 Simultaneous if/d req, d store BYTE addr 0x203 wdata 0xAB -> d granted first, o_mem_be 1000, o_mem_wdata 0xABABABAB, fetch granted at N+3.
REQ-028 d_req held continuously with if_req=1 -> grant order D,D,D,IF,D,D,D,IF.
REQ-029 Data WORD load addr 0x102 -> no o_mem_req, o_d_rvalid=1 and o_d_err=1 one cycle after gnt.
REQ-030 i_mem_gnt held low 5 cycles -> o_mem_req and fields stable throughout; response routed to correct owner.
REQ-031 Reset asserted in WAIT_RSP, rvalid arrives after release -> all outputs 0 during reset, no rvalid pulse, next request served normally.
